des_perm_pipe: RTL and testbench

Parametrised, pipelined DES permutation engine that applies either the initial permutation (IP) or the final permutation (FP = IP⁻¹) to 64-bit blocks. Each block's mode is selected per transfer, so mixed IP and FP traffic can be in flight together. A valid/ready handshake with full backpressure is used on both sides, and a saturating count of delivered blocks is kept. The block sits between the message input/key-schedule datapath and the round engine (IP) and between the round engine and the ciphertext output (FP), replacing the fixed combinational initial-permutation block.

---
 rtl/des_pkg.sv | 44 ++++
 rtl/des_perm_net.sv | 14 +
 rtl/des_perm_pipe.sv | 92 +++++++++
 tb/tb_des_perm_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES permutation tables and helpers. Tables hold DES bit numbers 1..64;
// entry i gives the input bit that lands on output bit i+1.
package des_pkg;

  localparam int DES_BLK_W = 64;

  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  // DES bit n lives at vector index 64-n, so DES bit 1 is the MSB.
  function automatic logic [DES_BLK_W-1:0] des_permute(input logic [DES_BLK_W-1:0] blk,
                                                        input logic mode);
    logic [DES_BLK_W-1:0] res;
    logic [5:0] src;
    logic [5:0] dst;
    res = '0;
    for (int i = 0; i < DES_BLK_W; i++) begin
      src = mode ? 6'(DES_BLK_W - FP_TBL[i]) : 6'(DES_BLK_W - IP_TBL[i]);
      dst = 6'(DES_BLK_W - 1 - i);
      res[dst] = blk[src];
    end
    return res;
  endfunction

endpackage

// File: rtl/des_perm_net.sv
// Combinational IP/FP permutation: fixed wiring per output bit plus a 2:1 mode mux.
module des_perm_net
  import des_pkg::*;
(
  input  logic                 mode,
  input  logic [DES_BLK_W-1:0] in,
  output logic [DES_BLK_W-1:0] out
);

  for (genvar i = 0; i < DES_BLK_W; i++) begin : g_bit
    assign out[DES_BLK_W-1-i] = mode ? in[DES_BLK_W-FP_TBL[i]] : in[DES_BLK_W-IP_TBL[i]];
  end

endmodule

// File: rtl/des_perm_pipe.sv
// Pipelined DES IP/FP engine with per-block mode, valid/ready backpressure on
// both sides and a saturating delivered-block counter.
module des_perm_pipe
  import des_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [DES_BLK_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_mode,
  output logic [DES_BLK_W-1:0] out_data,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     blk_cnt
);

  logic [STAGES-1:0]    v;
  logic [STAGES:0]      rdy;
  logic                 st_mode [STAGES];
  logic [DES_BLK_W-1:0] st_data [STAGES];
  logic [DES_BLK_W-1:0] perm_data;

  des_perm_net u_net (
    .mode (in_mode),
    .in   (in_data),
    .out  (perm_data)
  );

  // A stage can take new data if it is empty or everything downstream moves.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !v[k] || rdy[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                 up_v;
    logic                 up_m;
    logic [DES_BLK_W-1:0] up_d;
    logic                 v_q;
    logic                 m_q;
    logic [DES_BLK_W-1:0] d_q;

    if (k == 0) begin : g_head
      assign up_v = in_valid;
      assign up_m = in_mode;
      assign up_d = perm_data;
    end else begin : g_body
      assign up_v = v[k-1];
      assign up_m = st_mode[k-1];
      assign up_d = st_data[k-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
      end else if (rdy[k]) begin
        v_q <= up_v;
      end
      if (rdy[k] && up_v) begin
        m_q <= up_m;
        d_q <= up_d;
      end
    end

    assign v[k]       = v_q;
    assign st_mode[k] = m_q;
    assign st_data[k] = d_q;
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[STAGES-1];
  assign out_mode  = st_mode[STAGES-1];
  assign out_data  = st_data[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      blk_cnt <= '0;
    end else if (out_valid && out_ready && (blk_cnt != {CNT_W{1'b1}})) begin
      blk_cnt <= blk_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_des_perm_pipe.sv
// Scoreboard bench for des_perm_pipe: independent IP model (FP derived by inversion),
// known vectors, random round trips, backpressure, counter and reset scenarios.
module tb_des_perm_pipe;

  localparam int STAGES = 3;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic        mode;
    logic [63:0] data;
  } blk_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [63:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_mode;
  logic [63:0]      out_data;
  logic             cnt_clr;
  logic [CNT_W-1:0] blk_cnt;

  int total;
  int bad;

  blk_t src_q[$];
  blk_t res_q[$];
  blk_t sb_q[$];

  int ip_ref [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
  };

  des_perm_pipe #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_data  (out_data),
    .cnt_clr   (cnt_clr),
    .blk_cnt   (blk_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FP is built as the inverse of IP so a wrong FP table in the design shows up.
  function automatic logic [63:0] model_perm(input logic [63:0] x, input logic m);
    logic [63:0] y;
    y = '0;
    for (int i = 1; i <= 64; i++) begin
      if (!m) y[64-i] = x[64-ip_ref[i-1]];
      else    y[64-ip_ref[i-1]] = x[64-i];
    end
    return y;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives src_q through the DUT; every delivered block is checked against the scoreboard.
  task automatic run_stream(input int ready_pct, input int max_cycles);
    blk_t cur, exp_b, got;
    bit   have, prev_stall;
    blk_t prev_out;
    int   guard;
    have = 0; prev_stall = 0; guard = 0; cur = '0; prev_out = '0;
    res_q.delete();
    sb_q.delete();
    while ((src_q.size() > 0 || have || sb_q.size() > 0) && guard < max_cycles) begin
      if (!have && src_q.size() > 0) begin
        cur  = src_q.pop_front();
        have = 1;
      end
      in_valid  = have;
      in_mode   = cur.mode;
      in_data   = cur.data;
      out_ready = ($urandom_range(0, 99) < ready_pct);
      @(negedge clk);
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || {out_mode, out_data} !== prev_out) begin
          bad++;
          $display("[TB] FAIL stall_hold got=%b/%h exp=1/%h", out_valid, {out_mode, out_data}, prev_out);
        end
      end
      total++;
      if (in_ready !== (out_ready || sb_q.size() < STAGES)) begin
        bad++;
        $display("[TB] FAIL in_ready got=%b exp=%b (occ=%0d)", in_ready,
                 (out_ready || sb_q.size() < STAGES), sb_q.size());
      end
      if (out_valid && out_ready) begin
        got = '{out_mode, out_data};
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL spurious_out got=%h exp=none", got);
        end else begin
          exp_b = sb_q.pop_front();
          if (got !== exp_b) begin
            bad++;
            $display("[TB] FAIL out_block got=%h exp=%h", got, exp_b);
          end
        end
        res_q.push_back(got);
      end
      if (in_valid && in_ready) begin
        sb_q.push_back('{cur.mode, model_perm(cur.data, cur.mode)});
        have = 0;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = '{out_mode, out_data};
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (guard >= max_cycles) begin
      total++; bad++;
      $display("[TB] FAIL stream_timeout got=%0d exp<%0d", guard, max_cycles);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1)  begin bad++; $display("[TB] FAIL rst_in_ready got=%b exp=1", in_ready); end
    if (blk_cnt !== '0)     begin bad++; $display("[TB] FAIL rst_blk_cnt got=%0d exp=0", blk_cnt); end
  endtask

  task automatic test_ip_latency();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1; in_mode = 1'b0; in_data = 64'h0123456789ABCDEF;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL lat_in_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 1; c <= STAGES; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== (c == STAGES)) begin
        bad++;
        $display("[TB] FAIL lat_out_valid_c%0d got=%b exp=%b", c, out_valid, (c == STAGES));
      end
      if (c < STAGES) begin @(posedge clk); #1; end
    end
    total += 2;
    if (out_data !== 64'hCC00CCFFF0AAF0AA) begin
      bad++; $display("[TB] FAIL ip_vector got=%h exp=cc00ccfff0aaf0aa", out_data);
    end
    if (out_mode !== 1'b0) begin bad++; $display("[TB] FAIL ip_mode got=%b exp=0", out_mode); end
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    total += 2;
    if (blk_cnt !== 4'd1) begin bad++; $display("[TB] FAIL ip_blk_cnt got=%0d exp=1", blk_cnt); end
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL ip_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_vectors();
    logic [63:0] exp_d [7];
    do_reset();
    src_q.push_back('{1'b1, 64'hCC00CCFFF0AAF0AA}); exp_d[0] = 64'h0123456789ABCDEF;
    src_q.push_back('{1'b0, 64'h8000000000000000}); exp_d[1] = 64'h0000000001000000;
    src_q.push_back('{1'b0, 64'h0});                exp_d[2] = 64'h0;
    src_q.push_back('{1'b1, 64'h0});                exp_d[3] = 64'h0;
    src_q.push_back('{1'b0, '1});                   exp_d[4] = '1;
    src_q.push_back('{1'b1, '1});                   exp_d[5] = '1;
    src_q.push_back('{1'b0, 64'h0123456789ABCDEF}); exp_d[6] = 64'hCC00CCFFF0AAF0AA;
    run_stream(100, 100);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (i >= res_q.size() || res_q[i].data !== exp_d[i]) begin
        bad++;
        $display("[TB] FAIL vector_%0d got=%h exp=%h", i,
                 (i < res_q.size()) ? res_q[i].data : 64'hx, exp_d[i]);
      end
    end
  endtask

  task automatic test_roundtrip();
    logic [63:0] orig_q[$];
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      orig_q.push_back({$urandom(), $urandom()});
      src_q.push_back('{1'b0, orig_q[i]});
    end
    run_stream(100, 3000);
    foreach (res_q[i]) src_q.push_back('{1'b1, res_q[i].data});
    run_stream(100, 3000);
    total++;
    if (res_q.size() != 1000) begin
      bad++; $display("[TB] FAIL roundtrip_count got=%0d exp=1000", res_q.size());
    end
    for (int i = 0; i < res_q.size() && i < 1000; i++) begin
      total++;
      if (res_q[i].data !== orig_q[i]) begin
        bad++; $display("[TB] FAIL roundtrip_%0d got=%h exp=%h", i, res_q[i].data, orig_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 200; i++) src_q.push_back('{i[0], {$urandom(), $urandom()}});
    run_stream(30, 4000);
    total++;
    if (res_q.size() != 200) begin
      bad++; $display("[TB] FAIL bp_count got=%0d exp=200", res_q.size());
    end
  endtask

  task automatic test_counter();
    int w;
    do_reset();
    for (int i = 0; i < 14; i++) src_q.push_back('{1'b0, {$urandom(), $urandom()}});
    run_stream(100, 100);
    @(negedge clk);
    total++;
    if (blk_cnt !== 4'd14) begin bad++; $display("[TB] FAIL cnt_14 got=%0d exp=14", blk_cnt); end
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) src_q.push_back('{1'b1, {$urandom(), $urandom()}});
    run_stream(100, 100);
    @(negedge clk);
    total++;
    if (blk_cnt !== 4'd15) begin bad++; $display("[TB] FAIL cnt_sat got=%0d exp=15", blk_cnt); end
    @(posedge clk);
    #1 in_valid = 1'b1; in_mode = 1'b0; in_data = 64'h1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
    total++;
    if (!out_valid) begin bad++; $display("[TB] FAIL clr_wait got=%b exp=1", out_valid); end
    out_ready = 1'b1; cnt_clr = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    total += 2;
    if (blk_cnt !== '0) begin bad++; $display("[TB] FAIL cnt_clr_prio got=%0d exp=0", blk_cnt); end
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL clr_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 3; i++) src_q.push_back('{1'b0, {$urandom(), $urandom()}});
    run_stream(100, 100);
    out_ready = 1'b0;
    for (int i = 0; i < STAGES + 2; i++) begin
      in_valid = 1'b1; in_mode = i[0]; in_data = {$urandom(), $urandom()};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    total += 2;
    if (in_ready !== 1'b0)  begin bad++; $display("[TB] FAIL full_in_ready got=%b exp=0", in_ready); end
    if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL full_out_valid got=%b exp=1", out_valid); end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_out_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1)  begin bad++; $display("[TB] FAIL mid_rst_in_ready got=%b exp=1", in_ready); end
    if (blk_cnt !== '0)     begin bad++; $display("[TB] FAIL mid_rst_blk_cnt got=%0d exp=0", blk_cnt); end
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 0; i < STAGES + 3; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stale_block_%0d got=%b exp=0", i, out_valid); end
    end
    @(posedge clk); #1;
    src_q.push_back('{1'b1, 64'hCC00CCFFF0AAF0AA});
    run_stream(100, 50);
    total++;
    if (res_q.size() != 1 || res_q[0].data !== 64'h0123456789ABCDEF) begin
      bad++; $display("[TB] FAIL post_rst_block got=%0d blocks exp=1 block 0123456789abcdef", res_q.size());
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_ip_latency();
    test_vectors();
    test_roundtrip();
    test_backpressure();
    test_counter();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
